player_mover: RTL and testbench

- Parametrised successor to the fixed 4-switch player controller.
- Moves the player sprite on a grid of STEP-pixel cells within the visible area.
- Adds input synchronisation, single-step-on-press with hold-to-repeat, deterministic priority on simultaneous presses, respawn, enable gating and a per-move event pulse.
- Sits between the board switches and the renderer/collision logic; its position outputs feed the VGA sprite drawer.

---
 rtl/player_mover_pkg.sv | 14 +
 rtl/player_mover_if.sv | 26 ++
 rtl/button_sync.sv | 27 ++
 rtl/player_mover.sv | 182 ++++++++++++++++++
 tb/tb_player_mover.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/player_mover_pkg.sv
// Shared geometry defaults and direction encodings for the player mover.
package player_mover_pkg;

  localparam int unsigned H_DISPLAY_DEF     = 640;
  localparam int unsigned V_DISPLAY_DEF     = 480;
  localparam int unsigned PLAYER_WIDTH_DEF  = 32;
  localparam int unsigned PLAYER_HEIGHT_DEF = 32;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

endpackage

// File: rtl/player_mover_if.sv
// Switch/control inputs and sprite position outputs of the player mover.
interface player_mover_if #(
  parameter int unsigned POS_W = 10
);
  logic             SW1;
  logic             SW2;
  logic             SW3;
  logic             SW4;
  logic             ENABLE;
  logic             RESPAWN;
  logic [POS_W-1:0] player_x;
  logic [POS_W-1:0] player_y;
  logic             move_pulse;
  logic [1:0]       move_dir;
  logic             at_goal;

  modport master (
    output SW1, SW2, SW3, SW4, ENABLE, RESPAWN,
    input  player_x, player_y, move_pulse, move_dir, at_goal
  );

  modport slave (
    input  SW1, SW2, SW3, SW4, ENABLE, RESPAWN,
    output player_x, player_y, move_pulse, move_dir, at_goal
  );
endinterface

// File: rtl/button_sync.sv
// Parametrised-width two-flop synchroniser for asynchronous switch inputs.
module button_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture of the raw inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/player_mover.sv
// Grid-stepping player controller: step on press, hold-to-repeat, respawn and enable gating.
module player_mover
  import player_mover_pkg::*;
#(
  parameter int unsigned POS_W         = 10,
  parameter int unsigned H_DISPLAY     = H_DISPLAY_DEF,
  parameter int unsigned V_DISPLAY     = V_DISPLAY_DEF,
  parameter int unsigned PLAYER_WIDTH  = PLAYER_WIDTH_DEF,
  parameter int unsigned PLAYER_HEIGHT = PLAYER_HEIGHT_DEF,
  parameter int unsigned STEP          = 32,
  parameter int unsigned START_X       = 320,
  parameter int unsigned START_Y       = 448,
  parameter int unsigned HOLD_CYCLES   = 6000000,
  parameter int unsigned REPEAT_CYCLES = 3000000,
  parameter int unsigned CNT_W         = 32
) (
  input logic           CLK,
  input logic           RST_N,
  player_mover_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat, StWaitRel} state_e;

  localparam logic [POS_W:0]   StepExt  = (POS_W+1)'(STEP);
  localparam logic [POS_W:0]   XMaxExt  = (POS_W+1)'(H_DISPLAY - PLAYER_WIDTH);
  localparam logic [POS_W:0]   YMaxExt  = (POS_W+1)'(V_DISPLAY - PLAYER_HEIGHT);
  localparam logic [POS_W-1:0] StepPos  = POS_W'(STEP);
  localparam logic [POS_W-1:0] StartX   = POS_W'(START_X);
  localparam logic [POS_W-1:0] StartY   = POS_W'(START_Y);
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepLoad  = CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [POS_W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]       lat_dir_q, lat_dir_d;
  logic [1:0]       move_dir_q, move_dir_d;
  logic             pulse_q, pulse_d;

  logic [3:0]       sw_s;
  logic             req;
  logic [1:0]       sel_dir;
  logic             step_ok;
  logic             do_step;
  logic [POS_W-1:0] x_step, y_step;
  logic [POS_W:0]   x_ext, y_ext, x_right_ext, y_down_ext;

  button_sync #(
    .Width(4)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .d_i   ({bus.SW4, bus.SW3, bus.SW2, bus.SW1}),
    .q_o   (sw_s)
  );

  assign req         = |sw_s;
  assign x_ext       = {1'b0, x_q};
  assign y_ext       = {1'b0, y_q};
  assign x_right_ext = x_ext + StepExt;
  assign y_down_ext  = y_ext + StepExt;

  // Fixed priority up > down > left > right among synchronised switches.
  always_comb begin
    sel_dir = DIR_RIGHT;
    if (sw_s[0])      sel_dir = DIR_UP;
    else if (sw_s[1]) sel_dir = DIR_DOWN;
    else if (sw_s[2]) sel_dir = DIR_LEFT;
  end

  // Bounds check and target position for the selected direction; no partial moves.
  always_comb begin
    step_ok = 1'b0;
    x_step  = x_q;
    y_step  = y_q;
    unique case (sel_dir)
      DIR_UP: begin
        step_ok = y_ext >= StepExt;
        y_step  = y_q - StepPos;
      end
      DIR_DOWN: begin
        step_ok = y_down_ext <= YMaxExt;
        y_step  = y_q + StepPos;
      end
      DIR_LEFT: begin
        step_ok = x_ext >= StepExt;
        x_step  = x_q - StepPos;
      end
      DIR_RIGHT: begin
        step_ok = x_right_ext <= XMaxExt;
        x_step  = x_q + StepPos;
      end
    endcase
  end

  // Next-state: press/hold/repeat timing, respawn override, then step application.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    x_d        = x_q;
    y_d        = y_q;
    lat_dir_d  = lat_dir_q;
    move_dir_d = move_dir_q;
    pulse_d    = 1'b0;
    do_step    = 1'b0;

    if (bus.RESPAWN) begin
      x_d     = StartX;
      y_d     = StartY;
      timer_d = '0;
      state_d = StWaitRel;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.ENABLE && req) begin
            do_step   = 1'b1;
            lat_dir_d = sel_dir;
            timer_d   = HoldLoad;
            state_d   = StHold;
          end
        end
        StHold, StRepeat: begin
          if (!bus.ENABLE || !req) begin
            state_d = StIdle;
          end else if (sel_dir != lat_dir_q) begin
            // Direction change restarts the hold delay in the new direction.
            do_step   = 1'b1;
            lat_dir_d = sel_dir;
            timer_d   = HoldLoad;
            state_d   = StHold;
          end else if (timer_q == '0) begin
            do_step = 1'b1;
            timer_d = RepLoad;
            state_d = StRepeat;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        StWaitRel: begin
          if (!req) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      // A blocked step still consumes the timer/state transition above.
      if (do_step && step_ok) begin
        x_d        = x_step;
        y_d        = y_step;
        move_dir_d = sel_dir;
        pulse_d    = 1'b1;
      end
    end
  end

  // State, timer and position registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      x_q        <= StartX;
      y_q        <= StartY;
      lat_dir_q  <= DIR_UP;
      move_dir_q <= DIR_UP;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      x_q        <= x_d;
      y_q        <= y_d;
      lat_dir_q  <= lat_dir_d;
      move_dir_q <= move_dir_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bus.player_x   = x_q;
  assign bus.player_y   = y_q;
  assign bus.move_pulse = pulse_q;
  assign bus.move_dir   = move_dir_q;
  assign bus.at_goal    = (y_q == '0);

endmodule

// File: tb/tb_player_mover.sv
// Randomised and directed bench for player_mover against a behavioural model.
module tb_player_mover;

  localparam int HOLD    = 4;
  localparam int REP     = 2;
  localparam int STEP    = 32;
  localparam int START_X = 320;
  localparam int START_Y = 448;
  localparam int X_MAX   = 640 - 32;
  localparam int Y_MAX   = 480 - 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  player_mover_if #(.POS_W(10)) bus ();

  player_mover #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int npulse   = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state.
  int       mx = START_X;
  int       my = START_Y;
  int       mdir = 0;
  bit       mpulse = 1'b0;
  bit [3:0] s1 = '0;
  bit [3:0] s2 = '0;
  bit [3:0] msw;
  int       held = -1;   // direction currently held, -1 when none
  int       due = 0;     // edges remaining until the next automatic step
  bit       wrel = 1'b0; // waiting for all switches released after respawn
  int       md;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic try_step(input int d);
    int nx, ny;
    nx = mx;
    ny = my;
    case (d)
      0: ny = my - STEP;
      1: ny = my + STEP;
      2: nx = mx - STEP;
      default: nx = mx + STEP;
    endcase
    if (nx >= 0 && nx <= X_MAX && ny >= 0 && ny <= Y_MAX) begin
      mx = nx;
      my = ny;
      mdir = d;
      mpulse = 1'b1;
    end
  endtask

  // Reference model: switches visible two edges after sampling; step on press, then every
  // HOLD edges, then every REP edges while the same direction stays selected.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mx = START_X; my = START_Y; mdir = 0; mpulse = 1'b0;
      s1 = '0; s2 = '0; held = -1; due = 0; wrel = 1'b0;
    end else begin
      msw = s2;
      s2 = s1;
      s1 = {bus.SW4, bus.SW3, bus.SW2, bus.SW1};
      mpulse = 1'b0;
      if (bus.RESPAWN) begin
        mx = START_X; my = START_Y; wrel = 1'b1; held = -1;
      end else if (wrel) begin
        if (msw == 0) wrel = 1'b0;
      end else if (!bus.ENABLE || msw == 0) begin
        held = -1;
      end else begin
        md = msw[0] ? 0 : msw[1] ? 1 : msw[2] ? 2 : 3;
        if (md != held) begin
          try_step(md);
          held = md;
          due = HOLD;
        end else begin
          due--;
          if (due == 0) begin
            try_step(md);
            due = REP;
          end
        end
      end
    end
  end

  // Compare process: every falling edge once checking is enabled.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("x", int'(bus.player_x), mx);
      chk("y", int'(bus.player_y), my);
      chk("pulse", int'(bus.move_pulse), int'(mpulse));
      chk("dir", int'(bus.move_dir), mdir);
      chk("goal", int'(bus.at_goal), int'(my == 0));
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.move_pulse === 1'b1) npulse++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_sw(input bit [3:0] v);
    {bus.SW4, bus.SW3, bus.SW2, bus.SW1} = v;
  endtask

  task automatic respawn();
    bus.RESPAWN = 1'b1;
    cycles(1);
    bus.RESPAWN = 1'b0;
    cycles(2);
  endtask

  initial begin
    bit [3:0] v;
    int dur;
    set_sw(4'b0000);
    bus.ENABLE  = 1'b1;
    bus.RESPAWN = 1'b0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    cycles(3);
    chk("rst_x", int'(bus.player_x), 320);
    chk("rst_y", int'(bus.player_y), 448);
    chk("rst_pulse", int'(bus.move_pulse), 0);
    chk("rst_dir", int'(bus.move_dir), 0);
    chk("rst_goal", int'(bus.at_goal), 0);
    rst_n = 1'b1;
    cycles(2);

    // Single up pulse.
    npulse = 0;
    set_sw(4'b0001); cycles(1); set_sw(4'b0000); cycles(5);
    chk("t1_y", int'(bus.player_y), 416);
    chk("t1_x", int'(bus.player_x), 320);
    chk("t1_dir", int'(bus.move_dir), 0);
    chk("t1_pulses", npulse, 1);
    respawn();

    // Hold right until blocked at the edge.
    npulse = 0;
    set_sw(4'b1000); cycles(30); set_sw(4'b0000); cycles(4);
    chk("t2_x", int'(bus.player_x), 608);
    chk("t2_pulses", npulse, 9);
    respawn();

    // Up beats left; releasing up gives an immediate left step.
    set_sw(4'b0101); cycles(3);
    chk("t3_up_y", int'(bus.player_y), 416);
    chk("t3_up_x", int'(bus.player_x), 320);
    set_sw(4'b0100); cycles(3);
    chk("t3_left_x", int'(bus.player_x), 288);
    chk("t3_left_y", int'(bus.player_y), 416);
    set_sw(4'b0000); cycles(4);
    respawn();

    // Climb to the goal, then blocked up and blocked down.
    set_sw(4'b0001); cycles(40);
    chk("t4_y", int'(bus.player_y), 0);
    chk("t4_goal", int'(bus.at_goal), 1);
    set_sw(4'b0000); cycles(4);
    npulse = 0;
    set_sw(4'b0001); cycles(10); set_sw(4'b0000); cycles(4);
    chk("t4_up_block", npulse, 0);
    respawn();
    npulse = 0;
    set_sw(4'b0010); cycles(10); set_sw(4'b0000); cycles(4);
    chk("t4_dn_block", npulse, 0);
    chk("t4_dn_y", int'(bus.player_y), 448);

    // Respawn on the edge a repeat step is due.
    set_sw(4'b0100); cycles(6);
    chk("t5_pre_x", int'(bus.player_x), 288);
    bus.RESPAWN = 1'b1; cycles(1); bus.RESPAWN = 1'b0;
    chk("t5_x", int'(bus.player_x), 320);
    chk("t5_pulse", int'(bus.move_pulse), 0);
    chk("t5_dir", int'(bus.move_dir), 2);
    npulse = 0;
    cycles(10);
    chk("t5_held_pulses", npulse, 0);
    set_sw(4'b0000); cycles(4);
    set_sw(4'b0100); cycles(1); set_sw(4'b0000); cycles(4);
    chk("t5_repress_x", int'(bus.player_x), 288);
    respawn();

    // Random phase.
    for (int i = 0; i < 60; i++) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 4'b0000;
      set_sw(v);
      bus.ENABLE = ($urandom_range(0, 7) != 0);
      dur = $urandom_range(1, 20);
      if ($urandom_range(0, 11) == 0) begin
        bus.RESPAWN = 1'b1; cycles(1); bus.RESPAWN = 1'b0;
      end
      cycles(dur);
    end
    bus.ENABLE = 1'b1;
    set_sw(4'b0000); cycles(4);
    respawn();

    // Asynchronous reset in the middle of auto-repeat, then enable gating.
    set_sw(4'b1000); cycles(10);
    chk("t6_pre_x", int'(bus.player_x), 416);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_x", int'(bus.player_x), 320);
    chk("t6_async_y", int'(bus.player_y), 448);
    chk("t6_async_pulse", int'(bus.move_pulse), 0);
    chk("t6_async_dir", int'(bus.move_dir), 0);
    cycles(2);
    bus.ENABLE = 1'b0;
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      set_sw(4'($urandom_range(0, 15)));
      cycles(1);
    end
    cycles(3);
    chk("t6_en_x", int'(bus.player_x), 320);
    chk("t6_en_y", int'(bus.player_y), 448);
    chk("t6_en_pulses", npulse, 0);
    bus.ENABLE = 1'b1;
    set_sw(4'b0000);
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
